// File: rtl/mat_rd_pkg.sv
// Shared encodings and width helpers for the banked matrix read sequencer.
package mat_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic WALK_ROW = 1'b0;  // column index runs fastest
  localparam logic WALK_COL = 1'b1;  // row index runs fastest

  // Bits needed to count 0..x-1, never less than one bit.
  function automatic int cnt_w(input int x);
    return (x <= 2) ? 1 : $clog2(x);
  endfunction

  // Per-bank address width: each bank holds (M*M)/N words.
  function automatic int addr_w(input int n, input int m);
    return cnt_w((m * m) / n);
  endfunction

endpackage

// File: rtl/mem_read_mat_seq_if.sv
// Control handshake and banked read bus of the matrix read sequencer.
interface mem_read_mat_seq_if
  import mat_rd_pkg::*;
#(
  parameter int N   = 3,
  parameter int M   = 6,
  parameter int P_W = 4
) ();

  localparam int AW = addr_w(N, M);

  logic            start;
  logic            mode;
  logic [P_W-1:0]  passes;
  logic            stall;
  logic            busy;
  logic            done;
  logic [N*AW-1:0] rd_addr_bram;
  logic [N-1:0]    rd_en_bram;

  // Controller side: requests walks and observes the read bus.
  modport master (
    output start, mode, passes, stall,
    input  busy, done, rd_addr_bram, rd_en_bram
  );

  // Sequencer side.
  modport slave (
    input  start, mode, passes, stall,
    output busy, done, rd_addr_bram, rd_en_bram
  );

endinterface

// File: rtl/bank_skew_delay.sv
// N-stage {en, addr} delay line; tap b feeds bank b, giving one cycle of
// skew per bank. hold freezes every stage so alignment survives a stall.
module bank_skew_delay #(
  parameter int N  = 3,
  parameter int AW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            in_en,
  input  logic [AW-1:0]   in_addr,
  output logic [N-1:0]    tap_en,
  output logic [N*AW-1:0] tap_addr
);

  logic [N-1:0]    en_q, en_d;
  logic [N*AW-1:0] addr_q, addr_d;

  // Shift the issued slot one stage per non-held cycle.
  always_comb begin
    en_d   = en_q;
    addr_d = addr_q;
    if (!hold) begin
      en_d[0]          = in_en;
      addr_d[AW-1:0]   = in_addr;
      for (int b = 1; b < N; b++) begin
        en_d[b]               = en_q[b-1];
        addr_d[b*AW +: AW]    = addr_q[(b-1)*AW +: AW];
      end
    end
  end

  // Stage registers; also serve as the bank output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= '0;
      addr_q <= '0;
    end else begin
      en_q   <= en_d;
      addr_q <= addr_d;
    end
  end

  assign tap_en   = en_q;
  assign tap_addr = addr_q;

endmodule

// File: rtl/mem_read_mat_seq.sv
// Self-sequencing read-address generator for one row-banked M x M operand
// matrix. Walks row- or column-major for a run-time number of passes and
// presents each address to bank b with b cycles of skew.
module mem_read_mat_seq
  import mat_rd_pkg::*;
#(
  parameter int N   = 3,
  parameter int M   = 6,
  parameter int P_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_read_mat_seq_if.slave  bus
);

  localparam int AW = addr_w(N, M);
  localparam int R  = M / N;        // local rows per bank
  localparam int RW = cnt_w(R);
  localparam int CW = cnt_w(M);
  localparam int DW = cnt_w(N + 1);

  generate
    if (N < 1 || (M % N) != 0) begin : g_bad_cfg
      $error("mem_read_mat_seq: M must be a positive multiple of N");
    end
  endgenerate

  state_t         state_q, state_d;
  logic           mode_q, mode_d;
  logic [P_W-1:0] passes_q, passes_d;
  logic [P_W-1:0] pass_q, pass_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CW-1:0]  col_q, col_d;
  logic [DW-1:0]  drain_q, drain_d;
  logic           vld_p0_q, vld_p0_d;
  logic [AW-1:0]  addr_p0_q, addr_p0_d;

  logic           last_row, last_col;
  logic [AW-1:0]  issue_addr;

  assign last_row = (row_q == RW'(R - 1));
  assign last_col = (col_q == CW'(M - 1));
  // Max value is M*M/N-1, so the AW-bit result is exact.
  assign issue_addr = AW'(int'(row_q) * M + int'(col_q));

  // Next-state, counter and issue-slot logic; a stall holds everything.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    passes_d  = passes_q;
    pass_d    = pass_q;
    row_d     = row_q;
    col_d     = col_q;
    drain_d   = drain_q;
    vld_p0_d  = vld_p0_q;
    addr_p0_d = addr_p0_q;
    if (!bus.stall) begin
      vld_p0_d  = 1'b0;
      addr_p0_d = '0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d  = ISSUE;
            mode_d   = bus.mode;
            passes_d = (bus.passes == '0) ? P_W'(1) : bus.passes;
            pass_d   = '0;
            row_d    = '0;
            col_d    = '0;
          end
        end
        ISSUE: begin
          vld_p0_d  = 1'b1;
          addr_p0_d = issue_addr;
          if (mode_q == WALK_ROW) begin
            if (last_col) begin
              col_d = '0;
              row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
          end else begin
            if (last_row) begin
              row_d = '0;
              col_d = last_col ? '0 : col_q + CW'(1);
            end else begin
              row_d = row_q + RW'(1);
            end
          end
          if (last_row && last_col) begin
            pass_d = pass_q + P_W'(1);
            if (pass_q == passes_q - P_W'(1)) begin
              state_d = DRAIN;
              drain_d = '0;
            end
          end
        end
        DRAIN: begin
          // Let the final slot ripple through every bank stage.
          if (drain_q == DW'(N)) begin
            state_d = DONE;
          end else begin
            drain_d = drain_q + DW'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Control state and the issue register (pipeline stage p0).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= WALK_ROW;
      passes_q  <= '0;
      pass_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      drain_q   <= '0;
      vld_p0_q  <= 1'b0;
      addr_p0_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      passes_q  <= passes_d;
      pass_q    <= pass_d;
      row_q     <= row_d;
      col_q     <= col_d;
      drain_q   <= drain_d;
      vld_p0_q  <= vld_p0_d;
      addr_p0_q <= addr_p0_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);

  // Stage p0 -> per-bank skew stages; tap b is bank b's output register.
  bank_skew_delay #(
    .N  (N),
    .AW (AW)
  ) u_skew (
    .clk      (clk),
    .rst      (rst),
    .hold     (bus.stall),
    .in_en    (vld_p0_q),
    .in_addr  (addr_p0_q),
    .tap_en   (bus.rd_en_bram),
    .tap_addr (bus.rd_addr_bram)
  );

endmodule

// File: tb/tb_mem_read_mat_seq.sv
// Scoreboard bench for mem_read_mat_seq: main instance N=3/M=6 plus
// N=1/M=4 and N=4/M=8 instances for the parameter sweep.
module tb_mem_read_mat_seq;
  import mat_rd_pkg::*;

  localparam int NB  = 3;
  localparam int MM  = 6;
  localparam int RR  = MM / NB;
  localparam int NT  = MM * MM / NB;
  localparam int AW  = addr_w(NB, MM);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  logic stl_q = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  mem_read_mat_seq_if #(.N(3), .M(6), .P_W(4)) ifc ();
  mem_read_mat_seq_if #(.N(1), .M(4), .P_W(4)) if1 ();
  mem_read_mat_seq_if #(.N(4), .M(8), .P_W(4)) if4 ();

  mem_read_mat_seq #(.N(3), .M(6), .P_W(4)) dut  (.clk(clk), .rst(rst), .bus(ifc.slave));
  mem_read_mat_seq #(.N(1), .M(4), .P_W(4)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  mem_read_mat_seq #(.N(4), .M(8), .P_W(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    stl_q <= ifc.stall;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Main-instance scoreboard
  int   q[NB][$];
  int   cnt[NB];
  int   first[NB];
  int   last[NB];
  logic [AW-1:0] prev[NB];
  bit   mon_en = 1'b1;

  always @(negedge clk) begin
    logic [AW-1:0] a;
    int            e;
    if (mon_en) begin
      for (int b = 0; b < NB; b++) begin
        if (ifc.rd_en_bram[b]) begin
          a = ifc.rd_addr_bram[b*AW +: AW];
          if (stl_q) begin
            chk($sformatf("b%0d_frozen", b), 32'(a), 32'(prev[b]));
          end else if (q[b].size() == 0) begin
            chk($sformatf("b%0d_unexp_en", b), 1, 0);
          end else begin
            e = q[b].pop_front();
            chk($sformatf("b%0d_addr", b), 32'(a), e);
            if (cnt[b] == 0) first[b] = cyc;
            last[b] = cyc;
            cnt[b]++;
          end
          prev[b] = a;
        end
      end
    end
  end

  // Sweep-instance scoreboards
  int sq1[$];
  int sq4[4][$];
  int cnt1 = 0, first1 = 0, d1c = -1;
  int cnt4[4], first4[4];
  int d4c = -1;

  always @(negedge clk) begin
    int e;
    if (if1.rd_en_bram[0]) begin
      if (sq1.size() == 0) chk("s1_unexp_en", 1, 0);
      else begin
        e = sq1.pop_front();
        chk("s1_addr", 32'(if1.rd_addr_bram), e);
      end
      if (cnt1 == 0) first1 = cyc;
      cnt1++;
    end
    for (int b = 0; b < 4; b++) begin
      if (if4.rd_en_bram[b]) begin
        if (sq4[b].size() == 0) chk($sformatf("s4_b%0d_unexp_en", b), 1, 0);
        else begin
          e = sq4[b].pop_front();
          chk($sformatf("s4_b%0d_addr", b), 32'(if4.rd_addr_bram[b*4 +: 4]), e);
        end
        if (cnt4[b] == 0) first4[b] = cyc;
        cnt4[b]++;
      end
    end
    if (if1.done) d1c = cyc;
    if (if4.done) d4c = cyc;
  end

  // One walk on the main instance: m=mode, p=passes, stall of st_len cycles
  // after st_at issued addresses, poke=pulse start while busy and in DONE.
  task automatic run(input logic m, input int p, input int st_at, input int st_len, input bit poke);
    int pe, t, ee, dc, a;
    bit seen;
    pe = (p == 0) ? 1 : p;
    t  = pe * NT;
    @(negedge clk);
    for (int b = 0; b < NB; b++) begin
      cnt[b] = 0; first[b] = -1; last[b] = -1;
    end
    for (int pp = 0; pp < pe; pp++) begin
      for (int k = 0; k < NT; k++) begin
        a = m ? ((k % RR) * MM + k / RR) : k;
        for (int b = 0; b < NB; b++) q[b].push_back(a);
      end
    end
    ifc.mode   = m;
    ifc.passes = p[3:0];
    ifc.start  = 1'b1;
    @(posedge clk);
    #1;
    ee = cyc;
    ifc.start = 1'b0;
    if (poke) begin
      @(posedge clk); #1 ifc.start = 1'b1;
      @(posedge clk); #1 ifc.start = 1'b0;
    end
    if (st_len > 0) begin
      repeat (st_at) @(posedge clk);
      #1 ifc.stall = 1'b1;
      repeat (st_len) @(posedge clk);
      #1 ifc.stall = 1'b0;
    end
    seen = 1'b0;
    dc   = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (ifc.done) begin
        seen = 1'b1;
        dc   = cyc;
      end
    end
    chk("done_seen", 32'(seen), 1);
    if (seen) chk("done_lat", dc - ee, t + NB + 1 + st_len);
    if (poke) ifc.start = 1'b1;
    @(posedge clk);
    #1 ifc.start = 1'b0;
    @(negedge clk);
    chk("busy_fall", 32'(ifc.busy), 0);
    chk("done_pulse", 32'(ifc.done), 0);
    repeat (3) @(negedge clk);
    chk("busy_idle", 32'(ifc.busy), 0);
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("b%0d_left", b), q[b].size(), 0);
      chk($sformatf("b%0d_count", b), cnt[b], t);
      chk($sformatf("b%0d_lag", b), first[b] - ee, 2 + b);
    end
    chk("last_bank_end", last[NB-1] - ee, t + NB + st_len);
  endtask

  initial begin
    int  ee;
    bit  bad;
    ifc.start = 1'b0; ifc.mode = 1'b0; ifc.passes = '0; ifc.stall = 1'b0;
    if1.start = 1'b0; if1.mode = 1'b0; if1.passes = 4'd1; if1.stall = 1'b0;
    if4.start = 1'b0; if4.mode = 1'b0; if4.passes = 4'd1; if4.stall = 1'b0;
    for (int b = 0; b < 4; b++) begin cnt4[b] = 0; first4[b] = 0; end

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_en", 32'(ifc.rd_en_bram), 0);
    chk("rst_addr", 32'(ifc.rd_addr_bram), 0);
    chk("rst_busy", 32'(ifc.busy), 0);
    chk("rst_done", 32'(ifc.done), 0);

    run(WALK_ROW, 1, 0, 0, 1'b0);
    run(WALK_COL, 1, 0, 0, 1'b0);
    run(WALK_ROW, 2, 0, 0, 1'b0);
    run(WALK_ROW, 0, 0, 0, 1'b0);
    run(WALK_ROW, 1, 5, 3, 1'b0);
    run(WALK_ROW, 1, 0, 0, 1'b1);
    run(WALK_COL, 1, 0, 0, 1'b0);

    // Reset mid-walk aborts with no done pulse
    mon_en = 1'b0;
    @(negedge clk);
    ifc.mode = 1'b0; ifc.passes = 4'd1; ifc.start = 1'b1;
    @(posedge clk);
    #1 ifc.start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_en", 32'(ifc.rd_en_bram), 0);
    chk("abort_addr", 32'(ifc.rd_addr_bram), 0);
    chk("abort_busy", 32'(ifc.busy), 0);
    chk("abort_done", 32'(ifc.done), 0);
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ifc.done || ifc.busy || (ifc.rd_en_bram != '0)) bad = 1'b1;
    end
    chk("abort_quiet", 32'(bad), 0);

    // rst and start together: stays idle
    @(negedge clk);
    rst = 1'b1; ifc.start = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; ifc.start = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ifc.busy || (ifc.rd_en_bram != '0)) bad = 1'b1;
    end
    chk("rst_start_idle", 32'(bad), 0);
    mon_en = 1'b1;
    run(WALK_ROW, 1, 0, 0, 1'b0);

    // Parameter sweep: N=1/M=4 and N=4/M=8, row-major single pass
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      sq1.push_back(k);
      for (int b = 0; b < 4; b++) sq4[b].push_back(k);
    end
    cnt1 = 0; d1c = -1; d4c = -1;
    for (int b = 0; b < 4; b++) cnt4[b] = 0;
    if1.start = 1'b1; if4.start = 1'b1;
    @(posedge clk);
    #1 ee = cyc;
    if1.start = 1'b0; if4.start = 1'b0;
    repeat (40) @(negedge clk);
    chk("s1_count", cnt1, 16);
    chk("s1_lag", first1 - ee, 2);
    chk("s1_done_lat", d1c - ee, 16 + 1 + 1);
    chk("s1_left", sq1.size(), 0);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("s4_b%0d_count", b), cnt4[b], 16);
      chk($sformatf("s4_b%0d_lag", b), first4[b] - ee, 2 + b);
      chk($sformatf("s4_b%0d_left", b), sq4[b].size(), 0);
    end
    chk("s4_done_lat", d4c - ee, 16 + 4 + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
